// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit line encoder.
// Line states are packed as {d_plus, d_minus}.
package usb_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
      S_EOP1,
      S_EOP2,
      S_EOP_J
   } tx_state_e;

   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

   localparam int DEF_CLKS_PER_BIT = 4;
   localparam int DEF_STUFF_LEN    = 6;

   // NRZI level 1 is J, level 0 is K.
   function automatic logic [1:0] nrzi_line(input logic level);
      return level ? LINE_J : LINE_K;
   endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-time pacing counter: counts 0..CLKS_PER_BIT-1 and flags the last
// clock of each bit time; synchronous clear holds it at zero.
module usb_bit_timer
   import usb_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   output logic o_strobe
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_strobe = (r_cnt == CNT_LAST);

endmodule

// File: rtl/usb_tx_encoder.sv
// USB transmit line encoder: bit pacing, optional bit stuffing (USB_TX_STUFF_EN),
// NRZI onto D+/D-, and SE0-SE0-J end of packet.
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | line J, bit timer held cleared, waiting tx_start
// S_DATA  | one data or stuffed bit per strobe, NRZI on line
// S_EOP1  | first SE0 bit time
// S_EOP2  | second SE0 bit time
// S_EOP_J | J bit time closing the packet, eop_done at its end
module usb_tx_encoder
   import usb_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int STUFF_LEN    = DEF_STUFF_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic tx_start,
   input  logic serial_in,
   input  logic send_eop,
   output logic shift_enable,
   output logic d_plus,
   output logic d_minus,
   output logic tx_idle,
   output logic eop_done
);

   if (CLKS_PER_BIT < 2 || STUFF_LEN < 1) begin : g_param_chk
      $error("usb_tx_encoder: CLKS_PER_BIT must be >= 2 and STUFF_LEN >= 1");
   end

   tx_state_e  r_state, w_state_nxt;
   logic       r_level, w_level_nxt;
   logic [1:0] r_line,  w_line_nxt;
   logic       w_strobe;
   logic       w_timer_clr;
   logic       w_stuff;
   logic       w_shift;
   logic       w_eop_done;

   assign w_timer_clr = (r_state == S_IDLE);

   usb_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_timer_clr),
      .o_strobe (w_strobe)
   );

`ifdef USB_TX_STUFF_EN
   localparam int OW = $clog2(STUFF_LEN + 1);
   localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);

   logic [OW-1:0] r_ones;

   assign w_stuff = (r_state == S_DATA) && (r_ones == ONES_MAX);

   // Run length of transmitted ones; only meaningful while in DATA.
   always_ff @(posedge clk) begin
      if (rst || (r_state != S_DATA)) begin
         r_ones <= '0;
      end else if (w_strobe) begin
         if (w_stuff) begin
            r_ones <= '0;
         end else if (!send_eop) begin
            r_ones <= serial_in ? (r_ones + OW'(1)) : '0;
         end
      end
   end
`else
   assign w_stuff = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_level <= 1'b1;
         r_line  <= LINE_J;
      end else begin
         r_state <= w_state_nxt;
         r_level <= w_level_nxt;
         r_line  <= w_line_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_level_nxt = r_level;
      w_line_nxt  = r_line;
      w_shift     = 1'b0;
      w_eop_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_line_nxt = LINE_J;
            if (tx_start) begin
               w_state_nxt = S_DATA;
               w_level_nxt = 1'b1;
            end
         end
         S_DATA: begin
            if (w_strobe) begin
               // A pending stuffed zero outranks end of packet.
               if (w_stuff) begin
                  w_level_nxt = ~r_level;
                  w_line_nxt  = nrzi_line(~r_level);
               end else if (send_eop) begin
                  w_line_nxt  = LINE_SE0;
                  w_state_nxt = S_EOP1;
               end else begin
                  w_shift     = 1'b1;
                  w_level_nxt = serial_in ? r_level : ~r_level;
                  w_line_nxt  = nrzi_line(serial_in ? r_level : ~r_level);
               end
            end
         end
         S_EOP1: begin
            if (w_strobe) begin
               w_state_nxt = S_EOP2;
            end
         end
         S_EOP2: begin
            if (w_strobe) begin
               w_state_nxt = S_EOP_J;
               w_line_nxt  = LINE_J;
            end
         end
         S_EOP_J: begin
            if (w_strobe) begin
               w_state_nxt = S_IDLE;
               w_eop_done  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_line_nxt  = LINE_J;
         end
      endcase
   end

   assign d_plus       = r_line[1];
   assign d_minus      = r_line[0];
   assign shift_enable = w_shift;
   assign eop_done     = w_eop_done;
   assign tx_idle      = (r_state == S_IDLE);

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder; expectations follow USB_TX_STUFF_EN
// when the bench is built with that macro.
module tb_usb_tx_encoder;

   localparam logic [1:0] EXP_J   = 2'b10;
   localparam logic [1:0] EXP_K   = 2'b01;
   localparam logic [1:0] EXP_SE0 = 2'b00;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx_start = 1'b0;
   logic serial_in = 1'b0;
   logic send_eop = 1'b0;
   logic shift_enable, d_plus, d_minus, tx_idle, eop_done;
   logic [1:0] w_line;

   int n_chk = 0;
   int n_err = 0;
   int se_cnt = 0;
   int s0;

   usb_tx_encoder #(
      .CLKS_PER_BIT(4),
      .STUFF_LEN   (6)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_start     (tx_start),
      .serial_in    (serial_in),
      .send_eop     (send_eop),
      .shift_enable (shift_enable),
      .d_plus       (d_plus),
      .d_minus      (d_minus),
      .tx_idle      (tx_idle),
      .eop_done     (eop_done)
   );

   assign w_line = {d_plus, d_minus};

   always #5 clk = ~clk;

   always @(negedge clk) if (shift_enable) se_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic start_pkt();
      @(posedge clk); #1 tx_start = 1'b1;
      @(posedge clk); #1 tx_start = 1'b0;
   endtask

   // Entered in the first clock of a bit time; returns in the first clock of the next.
   task automatic send_bit(input string tag, input logic b, input logic exp_se,
                           input logic [1:0] exp_line, input logic pulse);
      serial_in = b;
      @(posedge clk); #1 tx_start = pulse;
      @(negedge clk); chk({tag, "_gap"}, shift_enable, 1'b0);
      @(posedge clk); #1 tx_start = 1'b0;
      @(posedge clk);
      @(negedge clk); chk({tag, "_se"}, shift_enable, exp_se);
      @(posedge clk); #1 chk({tag, "_line"}, w_line, exp_line);
   endtask

   // Entered in the first SE0 clock; measures SE0 and J lengths and the idle handoff.
   task automatic eop_check(input string tag);
      int n;
      int m;
      logic found;
      send_eop = 1'b0;
      n = 1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (w_line == EXP_SE0) n++;
         else break;
      end
      chk({tag, "_se0_len"}, n, 8);
      chk({tag, "_j_line"}, w_line, EXP_J);
      m = 1;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (eop_done) begin
            found = 1'b1;
            chk({tag, "_idle_at_done"}, tx_idle, 1'b0);
            break;
         end
         @(posedge clk); #1;
         m++;
      end
      chk({tag, "_done_seen"}, found, 1'b1);
      chk({tag, "_j_len"}, m, 4);
      @(posedge clk); #1;
      chk({tag, "_idle_after"}, tx_idle, 1'b1);
      chk({tag, "_done_pulse"}, eop_done, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [1:0] sync_exp [8];
      sync_exp = '{EXP_K, EXP_J, EXP_K, EXP_J, EXP_K, EXP_J, EXP_K, EXP_K};

      // reset and idle
      repeat (10) @(posedge clk);
      #1;
      chk("rst_line", w_line, EXP_J);
      chk("rst_idle", tx_idle, 1'b1);
      @(negedge clk);
      chk("rst_se", shift_enable, 1'b0);
      chk("rst_done", eop_done, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("idle_se_cnt", se_cnt, 0);
      chk("idle_line", w_line, EXP_J);

      // SYNC pattern
      s0 = se_cnt;
      start_pkt();
      chk("sync_busy", tx_idle, 1'b0);
      chk("sync_pre_line", w_line, EXP_J);
      for (int i = 0; i < 8; i++) begin
         send_bit("sync", (i == 7), 1'b1, sync_exp[i], 1'b0);
      end
      send_eop = 1'b1;
      send_bit("sync_eop", 1'b0, 1'b0, EXP_SE0, 1'b0);
      eop_check("sync");
      chk("sync_pulses", se_cnt - s0, 8);

      // eight ones, with a stray tx_start mid-packet
      s0 = se_cnt;
      start_pkt();
      for (int i = 0; i < 6; i++) begin
         send_bit("ones", 1'b1, 1'b1, EXP_J, (i == 3));
      end
`ifdef USB_TX_STUFF_EN
      send_bit("ones_stuff", 1'b1, 1'b0, EXP_K, 1'b0);
      send_bit("ones_tail", 1'b1, 1'b1, EXP_K, 1'b0);
      send_bit("ones_tail", 1'b1, 1'b1, EXP_K, 1'b0);
`else
      send_bit("ones_tail", 1'b1, 1'b1, EXP_J, 1'b0);
      send_bit("ones_tail", 1'b1, 1'b1, EXP_J, 1'b0);
`endif
      send_eop = 1'b1;
      send_bit("ones_eop", 1'b1, 1'b0, EXP_SE0, 1'b0);
      eop_check("ones");
      chk("ones_pulses", se_cnt - s0, 8);

      // six ones then end of packet: pending stuff goes out first
      s0 = se_cnt;
      start_pkt();
      for (int i = 0; i < 6; i++) begin
         send_bit("six", 1'b1, 1'b1, EXP_J, 1'b0);
      end
      send_eop = 1'b1;
`ifdef USB_TX_STUFF_EN
      send_bit("six_stuff", 1'b1, 1'b0, EXP_K, 1'b0);
`endif
      send_bit("six_eop", 1'b1, 1'b0, EXP_SE0, 1'b0);
      eop_check("six");
      chk("six_pulses", se_cnt - s0, 6);

      // reset during EOP1, then a clean restart
      start_pkt();
      send_bit("rp", 1'b0, 1'b1, EXP_K, 1'b0);
      send_eop = 1'b1;
      send_bit("rp_eop", 1'b0, 1'b0, EXP_SE0, 1'b0);
      send_eop = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rp_rst_line", w_line, EXP_J);
      chk("rp_rst_idle", tx_idle, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      chk("rp_rst_se", shift_enable, 1'b0);
      chk("rp_rst_done", eop_done, 1'b0);
      s0 = se_cnt;
      start_pkt();
      chk("rs_pre_line", w_line, EXP_J);
      send_bit("rs", 1'b0, 1'b1, EXP_K, 1'b0);
      send_bit("rs", 1'b1, 1'b1, EXP_K, 1'b0);
      send_bit("rs", 1'b0, 1'b1, EXP_J, 1'b0);
      send_eop = 1'b1;
      send_bit("rs_eop", 1'b0, 1'b0, EXP_SE0, 1'b0);
      eop_check("rs");
      chk("rs_pulses", se_cnt - s0, 3);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/usb_tx_encoder.md
# usb_tx_encoder

Serial line encoder for the USB transmitter, directly downstream of the transmit parallel-to-serial shift register. Paces bit consumption at the USB bit rate, pulses `shift_enable` to pull each data bit from the shift register's serial output, inserts a stuffed zero after six consecutive ones, NRZI-encodes the stream onto D+/D−, and generates the SE0-SE0-J end-of-packet sequence.

## Interface
- `CLKS_PER_BIT`, 4, system clocks per USB bit time (≥2)
- `STUFF_LEN`, 6, consecutive ones that force a stuffed zero
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `tx_start`  in  1  single-cycle pulse, begins packet; honoured only in IDLE
- `serial_in`  in  1  current data bit from shift register serial output
- `send_eop`  in  1  level; high at a strobe means no data bit remains, start EOP
- `shift_enable`  out  1  one-cycle pulse: `serial_in` consumed, advance shift register
- `d_plus`  out  1  USB D+ line
- `d_minus`  out  1  USB D− line
- `tx_idle`  out  1  high in IDLE
- `eop_done`  out  1  one-cycle pulse when EOP sequence completes

## Operation
- Bit timer: counter 0..CLKS_PER_BIT−1, cleared on `tx_start` and in IDLE; `strobe` when counter = CLKS_PER_BIT−1.
- States: IDLE, DATA, EOP1, EOP2, EOP_J.
- IDLE: line J (d_plus=1, d_minus=0); `tx_start` → DATA, ones count 0, NRZI level = J.
- DATA, at strobe, priority order:
  - ones count = STUFF_LEN → stuffed zero: toggle NRZI level, clear count, no `shift_enable`.
  - else `send_eop` → line SE0 (both 0), go EOP1.
  - else consume `serial_in`: pulse `shift_enable`; 0 toggles level and clears count; 1 holds level, count+1.
- DATA drive: d_plus = level, d_minus = ~level.
- EOP1 strobe → EOP2 (SE0 held); EOP2 strobe → line J, EOP_J; EOP_J strobe → IDLE, `eop_done` pulse.
- Stuffing applies to the last data bit: pending stuff is emitted before SE0.
- `tx_start` outside IDLE ignored; `send_eop` outside DATA ignored.
- `serial_in` sampled only at strobe.

## Timing
- Reset values: d_plus=1, d_minus=0, shift_enable=0, tx_idle=1, eop_done=0; state IDLE, counters 0.
- `rst` mid-packet: next cycle reset values; any partial bit abandoned.
- Line outputs registered, change only on the cycle after a strobe; each bit lasts CLKS_PER_BIT cycles.
- First data bit on line CLKS_PER_BIT cycles after `tx_start`.
- `shift_enable` asserts in the strobe cycle; shift register advances so new `serial_in` is valid by next strobe.
- EOP: SE0 for 2·CLKS_PER_BIT cycles, J for CLKS_PER_BIT cycles, then `eop_done`; `tx_idle` high the cycle after `eop_done`.
- Ones counter width $clog2(STUFF_LEN+1); saturates never (cleared at STUFF_LEN).

## Configuration
- `USB_TX_STUFF_EN` defined: bit stuffing as above.
- Undefined: ones counter and stuff insertion removed; every DATA strobe consumes a bit or starts EOP (raw NRZI for bring-up).

## Structure
- `usb_tx_pkg`: state enum, line-state constants (J, K, SE0 as {d_plus,d_minus}), default CLKS_PER_BIT and STUFF_LEN.
- Sub-module `usb_bit_timer`: strobe counter with synchronous clear.

## Test plan
- Reset, hold 10 cycles → d_plus=1, d_minus=0, tx_idle=1, no shift_enable.
- tx_start, serial_in bits 0,0,0,0,0,0,0,1 (SYNC) → line K,J,K,J,K,J,K,K, 8 shift_enable pulses 4 cycles apart.
- serial_in held 1 for 8 bits (stuffing on) → 6 held bits, one toggle with no shift_enable, 2 held bits: 9 bit times, 8 pulses.
- After 6 consecutive ones, send_eop high → stuffed toggle, then SE0 8 cycles, J 4 cycles, eop_done, tx_idle.
- tx_start pulsed mid-packet → ignored, bit timing unchanged.
- rst asserted during EOP1 → next cycle J, tx_idle=1; new tx_start restarts normally.
